// File: rtl/bm_case_encode_hs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bm_case_encode_hs_pkg                                             |
// | Brief  : Shared defaults and FSM state encoding for the case-encode bench. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package bm_case_encode_hs_pkg;

  localparam int BITS_DEF         = 2;
  localparam int ERR_CNT_BITS_DEF = 4;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bm_case_encode_hs_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bm_case_encode_hs_if                                              |
// | Brief  : Input/output valid-ready bus of the one-hot to binary encoder.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface bm_case_encode_hs_if #(
  parameter int BITS         = bm_case_encode_hs_pkg::BITS_DEF,
  parameter int ERR_CNT_BITS = bm_case_encode_hs_pkg::ERR_CNT_BITS_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic [(1<<BITS)-1:0]    in_onehot;
  logic                    out_valid;
  logic                    out_ready;
  logic [BITS-1:0]         out_code;
  logic                    out_err;
  logic [ERR_CNT_BITS-1:0] err_count;

  modport master (
    output in_valid, in_onehot, out_ready,
    input  in_ready, out_valid, out_code, out_err, err_count
  );

  modport slave (
    input  in_valid, in_onehot, out_ready,
    output in_ready, out_valid, out_code, out_err, err_count
  );

endinterface
`default_nettype wire

// File: rtl/bm_case_encode_hs_onehot_to_bin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bm_onehot_to_bin                                                  |
// | Brief  : Combinational one-hot to binary encoder, lowest set bit wins.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module bm_onehot_to_bin #(
  parameter int BITS = bm_case_encode_hs_pkg::BITS_DEF
) (
  input  wire logic [(1<<BITS)-1:0] i_onehot,
  output logic      [BITS-1:0]      o_code,
  output logic                      o_err
);

  localparam int W = 1 << BITS;

  generate
    if (BITS == 2) begin : g_casez
      // Exact one-hot patterns come first so the wildcard rows only see illegal words.
      always_comb begin
        o_code = '0;
        o_err  = 1'b1;
        casez (i_onehot)
          4'b0001: begin o_code = 2'd0; o_err = 1'b0; end
          4'b0010: begin o_code = 2'd1; o_err = 1'b0; end
          4'b0100: begin o_code = 2'd2; o_err = 1'b0; end
          4'b1000: begin o_code = 2'd3; o_err = 1'b0; end
          4'b???1: begin o_code = 2'd0; o_err = 1'b1; end
          4'b??10: begin o_code = 2'd1; o_err = 1'b1; end
          4'b?100: begin o_code = 2'd2; o_err = 1'b1; end
          default: begin o_code = 2'd0; o_err = 1'b1; end
        endcase
      end
    end else begin : g_loop
      always_comb begin
        o_code = '0;
        for (int i = W - 1; i >= 0; i--) begin
          if (i_onehot[i]) o_code = BITS'(i);
        end
        o_err = ~$onehot(i_onehot);
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/bm_case_encode_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bm_case_encode_hs                                                 |
// | Brief  : Registered one-hot encoder with single-entry valid/ready stage.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module bm_case_encode_hs
  import bm_case_encode_hs_pkg::*;
#(
  parameter int BITS         = BITS_DEF,
  parameter int ERR_CNT_BITS = ERR_CNT_BITS_DEF
) (
  input wire logic             clock,
  input wire logic             reset,
  bm_case_encode_hs_if.slave   bus
);

  localparam logic [ERR_CNT_BITS-1:0] C_ERR_MAX = '1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [BITS-1:0]         r_code;
  logic                    r_err;
  logic [ERR_CNT_BITS-1:0] r_err_cnt;
  logic [BITS-1:0]         w_enc_code;
  logic                    w_enc_err;
  logic                    w_in_ready;
  logic                    w_accept;

  bm_onehot_to_bin #(.BITS(BITS)) u_enc (
    .i_onehot (bus.in_onehot),
    .o_code   (w_enc_code),
    .o_err    (w_enc_err)
  );

  // Ready while empty or while the held word leaves this cycle: no bubble.
  assign w_in_ready = (r_state == ST_EMPTY) | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_accept)                     w_state_nxt = ST_FULL;
      ST_FULL:  if (bus.out_ready && !w_accept)   w_state_nxt = ST_EMPTY;
      default:                                    w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_code <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_code <= w_enc_code;
      r_err  <= w_enc_err;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_enc_err && (r_err_cnt != C_ERR_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_code  = r_code;
  assign bus.out_err   = r_err;
  assign bus.err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bm_case_encode_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bm_case_encode_hs                                              |
// | Brief  : Scoreboard bench for bm_case_encode_hs with a reference model.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bm_case_encode_hs;

  typedef struct {
    logic [1:0] code;
    logic       err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  logic m_full = 1'b0;
  int   m_cnt  = 0;

  bm_case_encode_hs_if #(.BITS(2), .ERR_CNT_BITS(4)) bus ();

  bm_case_encode_hs #(.BITS(2), .ERR_CNT_BITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic exp_t ref_encode(input logic [3:0] w);
    exp_t e;
    int   n   = 0;
    int   low = -1;
    for (int i = 0; i < 4; i++) begin
      if (w[i]) begin
        n++;
        if (low < 0) low = i;
      end
    end
    e.code = (n == 0) ? 2'd0 : low[1:0];
    e.err  = (n != 1);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; model state advances as the coming posedge will.
  task automatic cycle(input logic v, input logic [3:0] w, input logic rdy);
    exp_t e;
    logic exp_rdy;
    logic acc;
    @(negedge clock);
    bus.in_valid  = v;
    bus.in_onehot = w;
    bus.out_ready = rdy;
    #1;
    exp_rdy = !m_full || rdy;
    chk("in_ready",  int'(bus.in_ready),  int'(exp_rdy));
    chk("out_valid", int'(bus.out_valid), int'(m_full));
    chk("err_count", int'(bus.err_count), m_cnt);
    acc = v && exp_rdy;
    if (acc) begin
      e = ref_encode(w);
      sb.push_back(e);
      if (e.err && m_cnt < 15) m_cnt++;
    end
    m_full = acc || (m_full && !rdy);
  endtask

  task automatic model_clear();
    sb.delete();
    m_full = 1'b0;
    m_cnt  = 0;
  endtask

  // Monitor: compares the held word against the scoreboard head every cycle it is valid.
  always @(negedge clock) begin
    #2;
    if (!reset && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got out_valid=1 expected no word held at %0t", $time);
      end else begin
        chk("out_code", int'(bus.out_code), int'(sb[0].code));
        chk("out_err",  int'(bus.out_err),  int'(sb[0].err));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] w;
    // Reset with a live word on the input: nothing may be captured.
    bus.in_valid  = 1'b1;
    bus.in_onehot = 4'b0100;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_code",  int'(bus.out_code),  0);
    chk("rst_err_count", int'(bus.err_count), 0);
    chk("rst_in_ready",  int'(bus.in_ready),  1);
    repeat (2) @(negedge clock);
    chk("rst_out_valid_hold", int'(bus.out_valid), 0);
    chk("rst_in_ready_hold",  int'(bus.in_ready),  1);
    bus.in_valid = 1'b0;
    model_clear();
    reset = 1'b0;
    cycle(1'b0, 4'b0000, 1'b0);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    // Single word then drain.
    cycle(1'b1, 4'b1000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);

    // Back-pressure with a pending word, then same-edge replacement.
    cycle(1'b1, 4'b0010, 1'b0);
    repeat (3) cycle(1'b1, 4'b0100, 1'b0);
    chk("bp_code_hold", int'(bus.out_code), 1);
    cycle(1'b1, 4'b0100, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);

    // Streaming at full rate.
    for (int i = 0; i < 4; i++) begin
      w = 4'b0001 << i;
      cycle(1'b1, w, 1'b1);
    end
    cycle(1'b0, 4'b0000, 1'b1);

    // Illegal words.
    cycle(1'b1, 4'b0000, 1'b1);
    cycle(1'b1, 4'b0110, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    chk("illegal_err_count", int'(bus.err_count), 2);

    // Saturation, then reset while a word is held.
    repeat (20) cycle(1'b1, 4'b1010, 1'b1);
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    chk("sat_err_count", int'(bus.err_count), 15);
    @(negedge clock);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_err_count", int'(bus.err_count), 0);
    model_clear();
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) < 7) w = 4'b0001 << $urandom_range(0, 3);
      else                          w = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0);
    end
    repeat (3) cycle(1'b0, 4'b0000, 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
